// File: rtl/hermes_local_sink.sv
// hermes_local_sink: credit-based consumer for one Hermes router local port.
// Parses header/size/timestamp/packet-number/payload, checks and reports each packet.
`default_nettype none

module hermes_local_sink #(
  parameter int FLIT_WIDTH = 32,
  parameter int ADDR_X     = 0,
  parameter int ADDR_Y     = 0
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  rx_i,
  input  logic [FLIT_WIDTH-1:0] data_i,
  output logic                  credit_o,
  input  logic                  stall_i,
  input  logic [31:0]           time_i,
  output logic                  rpt_valid_o,
  output logic [15:0]           rpt_src_o,
  output logic [31:0]           rpt_size_o,
  output logic [31:0]           rpt_latency_o,
  output logic [31:0]           rpt_pkt_num_o,
  output logic [2:0]            rpt_err_o,
  output logic [31:0]           pkt_cnt_o,
  output logic [31:0]           err_cnt_o,
  output logic [31:0]           lat_max_o
);

  localparam logic [7:0] MY_X = ADDR_X[7:0];
  localparam logic [7:0] MY_Y = ADDR_Y[7:0];

  typedef enum logic [2:0] {HEADER, SIZE, TIME, PNUM, PAYLOAD} state_t;

  state_t      state;
  logic [15:0] src_q;
  logic [31:0] size_q;
  logic [31:0] lat_q;
  logic [31:0] pnum_q;
  logic [31:0] remaining;
  logic [31:0] exp_q;
  logic        addr_err_q;
  logic        pay_err_q;
  logic        short_q;

  logic        accept;
  logic        tail;
  logic [31:0] fin_size;
  logic [31:0] fin_lat;
  logic [31:0] fin_pnum;
  logic        fin_short;
  logic        fin_pay;
  logic [2:0]  fin_err;

  assign accept = rx_i & credit_o;

  // Final packet fields include the contribution of the flit being accepted,
  // so the report registers can be loaded on the tail edge itself.
  always_comb begin
    tail      = 1'b0;
    fin_size  = (state == SIZE) ? data_i : size_q;
    fin_lat   = (state == TIME) ? (time_i - data_i) : lat_q;
    fin_pnum  = (state == PNUM) ? data_i : pnum_q;
    fin_short = (state == SIZE) ? (data_i < 32'd2) : short_q;
    fin_pay   = pay_err_q | ((state == PAYLOAD) && (data_i != exp_q));
    fin_err   = {fin_pay, addr_err_q, fin_short};
    case (state)
      SIZE:                tail = accept && (data_i == 32'd0);
      TIME, PNUM, PAYLOAD: tail = accept && (remaining == 32'd1);
      default:             tail = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= HEADER;
      credit_o      <= 1'b0;
      src_q         <= '0;
      size_q        <= '0;
      lat_q         <= '0;
      pnum_q        <= '0;
      remaining     <= '0;
      exp_q         <= '0;
      addr_err_q    <= 1'b0;
      pay_err_q     <= 1'b0;
      short_q       <= 1'b0;
      rpt_valid_o   <= 1'b0;
      rpt_src_o     <= '0;
      rpt_size_o    <= '0;
      rpt_latency_o <= '0;
      rpt_pkt_num_o <= '0;
      rpt_err_o     <= '0;
      pkt_cnt_o     <= '0;
      err_cnt_o     <= '0;
      lat_max_o     <= '0;
    end else begin
      credit_o    <= ~stall_i;
      rpt_valid_o <= tail;

      if (accept) begin
        case (state)
          HEADER: begin
            src_q      <= data_i[31:16];
            addr_err_q <= (data_i[15:8] != MY_X) || (data_i[7:0] != MY_Y);
            lat_q      <= '0;
            pnum_q     <= '0;
            pay_err_q  <= 1'b0;
            state      <= SIZE;
          end
          SIZE: begin
            size_q    <= data_i;
            remaining <= data_i;
            short_q   <= fin_short;
            state     <= (data_i == 32'd0) ? HEADER : TIME;
          end
          TIME: begin
            lat_q     <= fin_lat;
            remaining <= remaining - 32'd1;
            state     <= (remaining == 32'd1) ? HEADER : PNUM;
          end
          PNUM: begin
            pnum_q    <= data_i;
            exp_q     <= 32'd3;
            remaining <= remaining - 32'd1;
            state     <= (remaining == 32'd1) ? HEADER : PAYLOAD;
          end
          PAYLOAD: begin
            pay_err_q <= fin_pay;
            exp_q     <= exp_q + 32'd1;
            remaining <= remaining - 32'd1;
            state     <= (remaining == 32'd1) ? HEADER : PAYLOAD;
          end
          default: state <= HEADER;
        endcase
      end

      if (tail) begin
        rpt_src_o     <= src_q;
        rpt_size_o    <= fin_size;
        rpt_latency_o <= fin_lat;
        rpt_pkt_num_o <= fin_pnum;
        rpt_err_o     <= fin_err;
        if (pkt_cnt_o != 32'hFFFF_FFFF)
          pkt_cnt_o <= pkt_cnt_o + 32'd1;
        if ((fin_err != 3'b000) && (err_cnt_o != 32'hFFFF_FFFF))
          err_cnt_o <= err_cnt_o + 32'd1;
        // A size-0 packet never carried a timestamp, so it cannot set the maximum.
        if ((fin_size != 32'd0) && (fin_lat > lat_max_o))
          lat_max_o <= fin_lat;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_hermes_local_sink.sv
// tb_hermes_local_sink: scoreboard bench; expected reports queued at send time,
// compared when rpt_valid_o pulses.
`default_nettype none

module tb_hermes_local_sink;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx = 1'b0;
  logic [31:0] data = '0;
  logic        credit;
  logic        stall = 1'b0;
  logic [31:0] time_v = '0;
  logic        rpt_valid;
  logic [15:0] rpt_src;
  logic [31:0] rpt_size, rpt_lat, rpt_pnum, pkt_cnt, err_cnt, lat_max;
  logic [2:0]  rpt_err;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [15:0] src;
    logic [31:0] size;
    logic [31:0] lat;
    logic [31:0] pnum;
    logic [2:0]  err;
    logic [31:0] pkt;
    logic [31:0] errc;
    logic [31:0] latmax;
  } rpt_t;

  rpt_t        sb[$];
  logic [31:0] m_pkt = 0, m_err = 0, m_lat = 0;
  logic        stall_en = 1'b0;

  hermes_local_sink #(.FLIT_WIDTH(32), .ADDR_X(1), .ADDR_Y(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .rx_i(rx), .data_i(data), .credit_o(credit),
    .stall_i(stall), .time_i(time_v), .rpt_valid_o(rpt_valid), .rpt_src_o(rpt_src),
    .rpt_size_o(rpt_size), .rpt_latency_o(rpt_lat), .rpt_pkt_num_o(rpt_pnum),
    .rpt_err_o(rpt_err), .pkt_cnt_o(pkt_cnt), .err_cnt_o(err_cnt), .lat_max_o(lat_max)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Present a flit and hold rx high until the sink has credit for it.
  task automatic send_flit(input logic [31:0] d, input logic [31:0] t);
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      rx = 1'b1; data = d; time_v = t;
      if (credit) begin
        @(posedge clk);
        return;
      end
    end
    chk("flit_timeout", 32'd0, 32'd1);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    rx = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_pkt(input logic [15:0] src, input logic [15:0] tgt, input logic [31:0] s,
                          input logic [31:0] ts, input logic [31:0] t, input logic [31:0] pnum,
                          input int bad_idx, input logic [31:0] bad_val);
    rpt_t e;
    logic [31:0] f;
    logic        perr;
    perr = 1'b0;
    for (int i = 4; i < int'(s) + 2; i++)
      if (i == bad_idx && bad_val != 32'(i - 1)) perr = 1'b1;
    e.src  = src;
    e.size = s;
    e.lat  = (s >= 1) ? t - ts : 32'd0;
    e.pnum = (s >= 2) ? pnum : 32'd0;
    e.err  = {perr, tgt != 16'h0101, s < 2};
    m_pkt  = m_pkt + 1;
    if (e.err != 3'b000) m_err = m_err + 1;
    if (s >= 1 && e.lat > m_lat) m_lat = e.lat;
    e.pkt = m_pkt; e.errc = m_err; e.latmax = m_lat;
    sb.push_back(e);
    for (int i = 0; i < int'(s) + 2; i++) begin
      case (i)
        0:       f = {src, tgt};
        1:       f = s;
        2:       f = ts;
        3:       f = pnum;
        default: f = (i == bad_idx) ? bad_val : 32'(i - 1);
      endcase
      send_flit(f, t);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rpt_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rpt", 32'd1, 32'd0);
      end else begin
        rpt_t e;
        e = sb.pop_front();
        chk("rpt_src", {16'd0, rpt_src}, {16'd0, e.src});
        chk("rpt_size", rpt_size, e.size);
        chk("rpt_latency", rpt_lat, e.lat);
        chk("rpt_pkt_num", rpt_pnum, e.pnum);
        chk("rpt_err", {29'd0, rpt_err}, {29'd0, e.err});
        chk("pkt_cnt", pkt_cnt, e.pkt);
        chk("err_cnt", err_cnt, e.errc);
        chk("lat_max", lat_max, e.latmax);
      end
    end
  end

  // Stall toggles every 3 cycles; credit must mirror ~stall one cycle later.
  initial begin
    int   cnt;
    logic prev, have_prev, exp_c;
    cnt = 0; prev = 1'b0; have_prev = 1'b0;
    forever begin
      @(negedge clk);
      if (stall_en) begin
        if (have_prev) begin
          exp_c = ~prev;
          chk("credit_follow", {31'd0, credit}, {31'd0, exp_c});
        end
        cnt++;
        if (cnt % 3 == 0) stall = ~stall;
        prev = stall;
        have_prev = 1'b1;
      end else begin
        have_prev = 1'b0;
      end
    end
  end

  task automatic check_cleared(input string tag);
    chk({tag, "_credit"}, {31'd0, credit}, 32'd0);
    chk({tag, "_rpt_valid"}, {31'd0, rpt_valid}, 32'd0);
    chk({tag, "_pkt_cnt"}, pkt_cnt, 32'd0);
    chk({tag, "_err_cnt"}, err_cnt, 32'd0);
    chk({tag, "_lat_max"}, lat_max, 32'd0);
    chk({tag, "_rpt_latency"}, rpt_lat, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check_cleared("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    send_pkt(16'h0000, 16'h0101, 4, 100, 137, 5, 0, 0);
    idle(2);
    send_pkt(16'h0000, 16'h0101, 4, 100, 137, 5, 5, 32'h9);
    idle(2);
    send_pkt(16'h0305, 16'h0200, 2, 50, 60, 7, 0, 0);
    idle(2);
    send_pkt(16'h0A0B, 16'h0101, 0, 0, 0, 0, 0, 0);
    send_pkt(16'h0C0D, 16'h0101, 1, 1000, 1003, 0, 0, 0);
    send_pkt(16'h0E0F, 16'h0101, 3, 10, 20, 9, 0, 0);
    idle(2);

    stall_en = 1'b1;
    send_pkt(16'h0000, 16'h0101, 4, 100, 137, 5, 0, 0);
    @(negedge clk);
    rx = 1'b0;
    stall_en = 1'b0;
    stall = 1'b0;
    idle(3);

    send_flit(32'h0000_0101, 0);
    send_flit(32'd6, 0);
    send_flit(32'd200, 210);
    send_flit(32'd11, 0);
    send_flit(32'd3, 0);
    send_flit(32'd4, 0);
    @(negedge clk);
    rx = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check_cleared("midrst");
    m_pkt = 0; m_err = 0; m_lat = 0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    send_pkt(16'h1122, 16'h0101, 3, 32'hFFFF_FFF0, 32'h10, 21, 0, 0);
    idle(5);

    chk("queue_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
